// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg
// Shared definitions for the SPI-over-APB byte sequencer:
//   - seq_state_e    : sequencer FSM state encoding
//   - ADDR_W/BYTE_W  : APB address and data widths
//   - DEF_*          : default APB register map of the SPI core
//   - POLL_LIMIT     : status polls allowed when SPI_SEQ_TIMEOUT_EN is defined
//   - is_access()    : true for the APB ACCESS phase states
package spi_seq_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned BYTE_W = 8;

   localparam logic [ADDR_W-1:0] DEF_DATA_ADDR   = 3'd5;
   localparam logic [ADDR_W-1:0] DEF_STATUS_ADDR = 3'd3;
   localparam int unsigned       DEF_SPIF_BIT    = 7;

   localparam int unsigned POLL_LIMIT = 255;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_SETUP  = 3'd1,
      WR_ACCESS = 3'd2,
      PL_SETUP  = 3'd3,
      PL_ACCESS = 3'd4,
      RD_SETUP  = 3'd5,
      RD_ACCESS = 3'd6
   } seq_state_e;

   function automatic logic is_access(input seq_state_e s);
      return (s == WR_ACCESS) || (s == PL_ACCESS) || (s == RD_ACCESS);
   endfunction

endpackage

// File: rtl/spi_apb_sequencer_if.sv
// spi_apb_sequencer_if
// Bundles the byte stream handshake, status flags and APB master bus of the
// sequencer.
//   master modport : the sequencer (drives tx_ready, rx_*, busy, err, APB request)
//   slave modport  : the environment (byte source, rx sink, APB completer)
interface spi_apb_sequencer_if;
   import spi_seq_pkg::*;

   logic              tx_valid;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_ready;
   logic              rx_valid;
   logic [BYTE_W-1:0] rx_data;
   logic              busy;
   logic              err;

   logic [ADDR_W-1:0] P_addr;
   logic              P_sel;
   logic              P_enable;
   logic              P_write;
   logic [BYTE_W-1:0] P_wdata;
   logic [BYTE_W-1:0] P_rdata;
   logic              P_ready;
   logic              P_slverr;

   modport master (
      input  tx_valid, tx_data, P_rdata, P_ready, P_slverr,
      output tx_ready, rx_valid, rx_data, busy, err,
             P_addr, P_sel, P_enable, P_write, P_wdata
   );

   modport slave (
      output tx_valid, tx_data, P_rdata, P_ready, P_slverr,
      input  tx_ready, rx_valid, rx_data, busy, err,
             P_addr, P_sel, P_enable, P_write, P_wdata
   );

endinterface

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo
// Byte FIFO holding transmit bytes until the sequencer picks them up.
// FIFO_DEPTH must be a power of two (2..16) so the pointers wrap naturally.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, data_i   : write request and byte (ignored when full)
//   pop_i            : read request (ignored when empty)
//   data_o           : head byte (valid when not empty)
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored bytes
module spi_seq_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        push_i,
   input  logic [7:0]                  data_i,
   input  logic                        pop_i,
   output logic [7:0]                  data_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the empty flag guards its contents.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer
// Takes bytes from an upstream valid/ready stream, queues them, and for each
// byte runs three APB transfers against an SPI core: write DATA, poll STATUS
// until the transfer-complete flag is set, read DATA back. The byte read back
// is presented as a one-cycle rx_valid pulse. Any slave error aborts the
// current byte and sets a sticky err flag.
// Ports:
//   P_clk, P_rst : clock, asynchronous active-high reset
//   bus          : spi_apb_sequencer_if.master (tx stream, rx pulse, busy/err,
//                  APB master request and completer response)
// Optional feature: define SPI_SEQ_TIMEOUT_EN to bound status polling; the
// 255th poll without the flag set raises err and drops the byte.
module spi_apb_sequencer
   import spi_seq_pkg::*;
#(
   parameter int unsigned       FIFO_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] DATA_ADDR   = DEF_DATA_ADDR,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter int unsigned       SPIF_BIT    = DEF_SPIF_BIT
) (
   input logic                 P_clk,
   input logic                 P_rst,
   spi_apb_sequencer_if.master bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   seq_state_e        state_q, state_d;
   logic              push, pop;
   logic              fifo_full, fifo_empty;
   logic [BYTE_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic [BYTE_W-1:0] hold_q;
   logic              rx_valid_q;
   logic [BYTE_W-1:0] rx_data_q;
   logic              err_q;
   logic              rx_load, err_set;
   logic              spif, poll_expired;

   logic              apb_sel, apb_enable, apb_write;
   logic [ADDR_W-1:0] apb_addr;
   logic [BYTE_W-1:0] apb_wdata;

   // A full FIFO refuses the push even when the sequencer pops in that cycle.
   assign push = bus.tx_valid && !fifo_full;
   assign spif = bus.P_rdata[SPIF_BIT];

   spi_seq_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (P_clk),
      .rst_i   (P_rst),
      .push_i  (push),
      .data_i  (bus.tx_data),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef SPI_SEQ_TIMEOUT_EN
   logic [7:0] poll_cnt_q, poll_cnt_d;

   // Counter holds the number of failed polls for the current byte.
   assign poll_expired = (poll_cnt_q == 8'(POLL_LIMIT - 1));

   always_comb begin
      poll_cnt_d = poll_cnt_q;
      if (state_q == WR_ACCESS && state_d == PL_SETUP)
         poll_cnt_d = '0;
      else if (state_q == PL_ACCESS && bus.P_ready && !bus.P_slverr && !spif)
         poll_cnt_d = poll_cnt_q + 8'd1;
   end

   always_ff @(posedge P_clk or posedge P_rst) begin
      if (P_rst) poll_cnt_q <= '0;
      else       poll_cnt_q <= poll_cnt_d;
   end
`else
   assign poll_expired = 1'b0;
`endif

   // State register
   always_ff @(posedge P_clk or posedge P_rst) begin
      if (P_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      rx_load = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = WR_SETUP;
            end
         end
         WR_SETUP: state_d = WR_ACCESS;
         WR_ACCESS: begin
            if (bus.P_ready) begin
               if (bus.P_slverr) begin
                  err_set = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = PL_SETUP;
               end
            end
         end
         PL_SETUP: state_d = PL_ACCESS;
         PL_ACCESS: begin
            if (bus.P_ready) begin
               if (bus.P_slverr || (!spif && poll_expired)) begin
                  err_set = 1'b1;
                  state_d = IDLE;
               end else if (spif) begin
                  state_d = RD_SETUP;
               end else begin
                  state_d = PL_SETUP;
               end
            end
         end
         RD_SETUP: state_d = RD_ACCESS;
         RD_ACCESS: begin
            if (bus.P_ready) begin
               if (bus.P_slverr) begin
                  err_set = 1'b1;
               end else begin
                  rx_load = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // APB request outputs
   always_comb begin
      apb_sel   = 1'b0;
      apb_write = 1'b0;
      apb_addr  = '0;
      apb_wdata = '0;
      unique case (state_q)
         WR_SETUP, WR_ACCESS: begin
            apb_sel   = 1'b1;
            apb_write = 1'b1;
            apb_addr  = DATA_ADDR;
            apb_wdata = hold_q;
         end
         PL_SETUP, PL_ACCESS: begin
            apb_sel  = 1'b1;
            apb_addr = STATUS_ADDR;
         end
         RD_SETUP, RD_ACCESS: begin
            apb_sel  = 1'b1;
            apb_addr = DATA_ADDR;
         end
         default: ;
      endcase
      apb_enable = is_access(state_q);
   end

   // Byte in flight; only meaningful outside IDLE, so no reset.
   always_ff @(posedge P_clk) begin
      if (pop) hold_q <= fifo_head;
   end

   always_ff @(posedge P_clk or posedge P_rst) begin
      if (P_rst) begin
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         rx_valid_q <= rx_load;
         if (rx_load) rx_data_q <= bus.P_rdata;
         if (err_set) err_q <= 1'b1;
      end
   end

   assign bus.tx_ready = !fifo_full;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.busy     = (state_q != IDLE) || (fifo_count != '0);
   assign bus.err      = err_q;
   assign bus.P_sel    = apb_sel;
   assign bus.P_enable = apb_enable;
   assign bus.P_write  = apb_write;
   assign bus.P_addr   = apb_addr;
   assign bus.P_wdata  = apb_wdata;

endmodule
